// File: rtl/uart_pkg.sv
// Shared definitions for the uart_tx8 serializer.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit to every frame).
package uart_pkg;

   localparam int unsigned DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
   localparam int unsigned FRAME_BITS = DATA_BITS + 3;
`else
   localparam int unsigned FRAME_BITS = DATA_BITS + 2;
`endif

   // Level of TXD between frames (mark)
   localparam logic IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
      StParity = 3'd3,
`endif
      StStop   = 3'd4
   } state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts CP cycles 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic CP,
   input  logic MR,
   input  logic CLR,
   output logic TICK
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign TICK = (cnt_q == LAST);

   // Next count: held at zero while cleared, wraps after the last cycle of a bit
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (CLR || TICK) begin
         cnt_d = '0;
      end
   end

   // Counter register with synchronous reset
   always_ff @(posedge CP) begin
      if (MR) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx8.sv
// uart_tx8: captures a byte on _LOAD low and sends start, 8 data bits LSB-first,
// optional even parity, and stop on TXD. BUSY/DONE form the reload handshake.
// Optional feature macro: UART_TX_PARITY_EN.
module uart_tx8
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned LOG          = 0
) (
   input  logic       CP,
   input  logic       MR,
   input  logic [7:0] D,
   input  logic       _LOAD,
   output logic       TXD,
   output logic       BUSY,
   output logic       DONE
);

   // Parameter sanity; LOG is kept for interface compatibility, tracing lives outside the RTL
   if (CLKS_PER_BIT < 2) begin : g_bad_clks
      $error("uart_tx8: CLKS_PER_BIT must be >= 2");
   end
   if (LOG > 1) begin : g_bad_log
      $error("uart_tx8: LOG must be 0 or 1");
   end

   state_e     state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] idx_q, idx_d;
   logic       txd_q, txd_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       tick;
   logic       bit_clr;
`ifdef UART_TX_PARITY_EN
   logic       par_q, par_d;
`endif

   // Timer sits at zero in IDLE so the start bit gets a full period after accept
   assign bit_clr = (state_q == StIdle);

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .CP  (CP),
      .MR  (MR),
      .CLR (bit_clr),
      .TICK(tick)
   );

   // Next-state logic: accept, bit sequencing, shift and parity accumulation
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (!_LOAD) begin
               state_d = StStart;
               shift_d = D;
               idx_d   = '0;
`ifdef UART_TX_PARITY_EN
               par_d   = 1'b0;
`endif
            end
         end
         StStart: begin
            if (tick) begin
               state_d = StData;
            end
         end
         StData: begin
            if (tick) begin
`ifdef UART_TX_PARITY_EN
               par_d   = par_q ^ shift_q[0];
`endif
               shift_d = shift_q >> 1;
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (tick) begin
               state_d = StStop;
            end
         end
`endif
         StStop: begin
            if (tick) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Output decode from the upcoming state so TXD/BUSY come straight from flops
   always_comb begin
      txd_d  = IDLE_LEVEL;
      busy_d = 1'b1;
      unique case (state_d)
         StIdle:   busy_d = 1'b0;
         StStart:  txd_d  = 1'b0;
         StData:   txd_d  = shift_d[0];
`ifdef UART_TX_PARITY_EN
         StParity: txd_d  = par_d;
`endif
         StStop:   txd_d  = 1'b1;
         default:  busy_d = 1'b0;
      endcase
   end

   // State and output registers; MR aborts any frame without a DONE
   always_ff @(posedge CP) begin
      if (MR) begin
         state_q <= StIdle;
         shift_q <= '0;
         idx_q   <= '0;
         txd_q   <= IDLE_LEVEL;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign TXD  = txd_q;
   assign BUSY = busy_q;
   assign DONE = done_q;

endmodule
